dport_arb: RTL and testbench
============================

// Module: dport_arb
// PURPOSE
//  Two-master arbiter for one dport (data-memory port, as driven by riscv_core mem_d_*) feeding dport_mux.
//  Master 0 is the CPU core. Master 1 is a secondary requester (debug/DMA).
//  Grants in round-robin order, holds the grant across back-pressure, and returns in-order responses
//  to the issuing master via an outstanding-request ID FIFO.
// PARAMETERS
//  TAG_W          11  width of req/resp tag
//  OUTSTANDING    4   max requests accepted downstream but not yet acked (power of 2)
//  OUTSTANDING_W  2   log2(OUTSTANDING)
// PORTS
//  clk_i                 in   1      clock
//  rst_ni                in   1      async active-low reset
//  mN_addr_i (N=0,1)     in   32     master N request address
//  mN_data_wr_i          in   32     master N write data
//  mN_rd_i               in   1      master N read request
//  mN_wr_i               in   4      master N byte write strobes
//  mN_cacheable_i        in   1      master N cacheable attribute
//  mN_req_tag_i          in   TAG_W  master N request tag
//  mN_invalidate_i / mN_writeback_i / mN_flush_i  in 1  master N cache-maintenance requests
//  mN_accept_o           out  1      master N request taken this cycle
//  mN_ack_o              out  1      master N response valid
//  mN_data_rd_o          out  32     master N read data
//  mN_error_o            out  1      master N response error
//  mN_resp_tag_o         out  TAG_W  master N response tag
//  mem_addr_o, mem_data_wr_o, mem_rd_o, mem_wr_o, mem_cacheable_o, mem_req_tag_o,
//  mem_invalidate_o, mem_writeback_o, mem_flush_o   out  as above  downstream request
//  mem_accept_i          in   1      downstream took request
//  mem_ack_i             in   1      downstream response valid (in issue order)
//  mem_data_rd_i         in   32     downstream read data
//  mem_error_i           in   1      downstream error
//  mem_resp_tag_i        in   TAG_W  downstream response tag
//  busy_o                out  1      outstanding count != 0
// BEHAVIOUR
//  - reqN = mN_rd_i | (|mN_wr_i) | mN_invalidate_i | mN_writeback_i | mN_flush_i.
//  - Reset (rst_ni=0, async): rr_ptr=0 (master 0 preferred), lock=0, FIFO empty, count=0.
//    All outputs are combinational from these and are 0 during reset: accept/ack/error/busy=0, data/tag=0.
//  - Grant selection is combinational, zero added latency:
//    - lock=1: grant = locked_id.
//    - else, one requester: grant that requester.
//    - else, both requesting: grant = rr_ptr.
//  - Downstream request = granted master's fields. All request outputs are 0 if no request, or if count==OUTSTANDING (full).
//  - mN_accept_o = mem_accept_i & grant==N & !full. Requests of the non-granted master see accept=0.
//  - Hold: if the granted master's request is presented and not accepted, set lock=1, locked_id=grant.
//    Lock clears on the accept cycle. Masters hold their request stable until accepted.
//  - On accept: push grant id into the FIFO, and set rr_ptr = ~grant.
//  - Response: on mem_ack_i, route data/error/tag to the master at FIFO head and pop. The other master's ack_o=0.
//    Response fields are combinational pass-through, so response latency is 0.
//  - Simultaneous accept+ack: push and pop in the same cycle; count unchanged; pointers wrap modulo OUTSTANDING.
//  - Full: no new accepts. An ack in the full cycle does not unblock the same cycle (full is registered count).
//  - Ack with empty FIFO: dropped; no master ack.
//  - Reset mid-transaction: FIFO and lock cleared. Later stray acks are dropped as above.
// STRUCTURE
//  - Package dport_pkg: TAG_W default; dport_req_t struct (addr, data_wr, rd, wr, cacheable, tag, inv, wb, flush)
//    and dport_resp_t struct (data_rd, error, tag).
//  - One sub-module: dport_arb_idfifo (1-bit wide, OUTSTANDING deep, push/pop/full/empty/count),
//    async active-low reset.
// TESTING
//  1. m0 read 0x100, tag 5, mem_accept=1, ack 2 cycles later with data 0xDEADBEEF.
//     -> m0_accept same cycle; m0_ack with 0xDEADBEEF, tag 5; m1 sees nothing.
//  2. m0 and m1 both request every cycle, always accepted.
//     -> grants alternate 0,1,0,1 from reset; acks return to masters in the same order.
//  3. m1 write 0x200 strobe 0xF with mem_accept=0 for 3 cycles while m0 requests.
//     -> m1 stays granted until accepted; m0 accepted the cycle after.
//  4. 4 accepts with no ack -> busy_o=1, 5th request sees accept=0 and mem_rd_o=0.
//     One ack -> the next cycle accepts again.
//  5. Accept+ack in the same cycle, repeated 10 times over FIFO wrap -> count constant; routing correct.
//  6. Assert rst_ni=0 with 2 outstanding, release, then ack.
//     -> no mN_ack_o; busy_o=0; next m0 request granted first.

Source files
------------

// File: rtl/dport_pkg.sv
// Shared types for the two-master dport arbiter: request/response bundles and tag width.
package dport_pkg;

    localparam int DPORT_TAG_W = 11;

    typedef struct packed {
        logic [31:0]            addr;
        logic [31:0]            data_wr;
        logic                   rd;
        logic [3:0]             wr;
        logic                   cacheable;
        logic [DPORT_TAG_W-1:0] tag;
        logic                   inv;
        logic                   wb;
        logic                   flush;
    } dport_req_t;

    typedef struct packed {
        logic [31:0]            data_rd;
        logic                   error;
        logic [DPORT_TAG_W-1:0] tag;
    } dport_resp_t;

    function automatic logic req_active(input dport_req_t r);
        return r.rd | (|r.wr) | r.inv | r.wb | r.flush;
    endfunction

endpackage

// File: rtl/dport_arb_idfifo.sv
// Outstanding-request ID FIFO: records which master issued each accepted request, in order.
module dport_arb_idfifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               push_id_i,
    input  logic               pop_i,
    output logic               head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [DEPTH_W:0]   count_o
);

    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

    logic [DEPTH-1:0]   mem_q, mem_d;
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dport_arb.sv
// Round-robin two-master arbiter for a data-memory port, with grant hold across back-pressure
// and in-order response routing through an ID FIFO.
module dport_arb
    import dport_pkg::*;
#(
    parameter int TAG_W         = DPORT_TAG_W,
    parameter int OUTSTANDING   = 4,
    parameter int OUTSTANDING_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m0_data_wr_i,
    input  logic             m0_rd_i,
    input  logic [3:0]       m0_wr_i,
    input  logic             m0_cacheable_i,
    input  logic [TAG_W-1:0] m0_req_tag_i,
    input  logic             m0_invalidate_i,
    input  logic             m0_writeback_i,
    input  logic             m0_flush_i,
    output logic             m0_accept_o,
    output logic             m0_ack_o,
    output logic [31:0]      m0_data_rd_o,
    output logic             m0_error_o,
    output logic [TAG_W-1:0] m0_resp_tag_o,
    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m1_data_wr_i,
    input  logic             m1_rd_i,
    input  logic [3:0]       m1_wr_i,
    input  logic             m1_cacheable_i,
    input  logic [TAG_W-1:0] m1_req_tag_i,
    input  logic             m1_invalidate_i,
    input  logic             m1_writeback_i,
    input  logic             m1_flush_i,
    output logic             m1_accept_o,
    output logic             m1_ack_o,
    output logic [31:0]      m1_data_rd_o,
    output logic             m1_error_o,
    output logic [TAG_W-1:0] m1_resp_tag_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_wr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    output logic             mem_cacheable_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    output logic             mem_invalidate_o,
    output logic             mem_writeback_o,
    output logic             mem_flush_o,
    input  logic             mem_accept_i,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_data_rd_i,
    input  logic             mem_error_i,
    input  logic [TAG_W-1:0] mem_resp_tag_i,
    output logic             busy_o
);

    dport_req_t  req_in [2];
    dport_req_t  req_out;
    dport_resp_t resp_in;
    dport_resp_t resp_out [2];
    logic [1:0]  req_v;

    logic rr_q, rr_d;
    logic lock_q, lock_d;
    logic locked_id_q, locked_id_d;
    logic grant, grant_req, issue, accept_fire, ack_fire;
    logic fifo_head, fifo_full, fifo_empty;
    logic [OUTSTANDING_W:0] fifo_count;

    always_comb begin
        req_in[0] = '{addr: m0_addr_i, data_wr: m0_data_wr_i, rd: m0_rd_i, wr: m0_wr_i,
                      cacheable: m0_cacheable_i, tag: m0_req_tag_i, inv: m0_invalidate_i,
                      wb: m0_writeback_i, flush: m0_flush_i};
        req_in[1] = '{addr: m1_addr_i, data_wr: m1_data_wr_i, rd: m1_rd_i, wr: m1_wr_i,
                      cacheable: m1_cacheable_i, tag: m1_req_tag_i, inv: m1_invalidate_i,
                      wb: m1_writeback_i, flush: m1_flush_i};
        req_v[0]  = req_active(req_in[0]);
        req_v[1]  = req_active(req_in[1]);
    end

    always_comb begin
        if (lock_q)                    grant = locked_id_q;
        else if (req_v[0] && !req_v[1]) grant = 1'b0;
        else if (req_v[1] && !req_v[0]) grant = 1'b1;
        else                           grant = rr_q;
    end

    // Everything customer-visible is gated by rst_ni so outputs read as zero throughout reset.
    assign grant_req   = req_v[grant];
    assign issue       = rst_ni & grant_req & ~fifo_full;
    assign accept_fire = issue & mem_accept_i;
    assign ack_fire    = rst_ni & mem_ack_i & ~fifo_empty;
    assign req_out     = issue ? req_in[grant] : '0;

    assign mem_addr_o       = req_out.addr;
    assign mem_data_wr_o    = req_out.data_wr;
    assign mem_rd_o         = req_out.rd;
    assign mem_wr_o         = req_out.wr;
    assign mem_cacheable_o  = req_out.cacheable;
    assign mem_req_tag_o    = req_out.tag;
    assign mem_invalidate_o = req_out.inv;
    assign mem_writeback_o  = req_out.wb;
    assign mem_flush_o      = req_out.flush;

    assign m0_accept_o = accept_fire & (grant == 1'b0);
    assign m1_accept_o = accept_fire & (grant == 1'b1);

    always_comb begin
        resp_in     = '{data_rd: mem_data_rd_i, error: mem_error_i, tag: mem_resp_tag_i};
        resp_out[0] = (ack_fire && fifo_head == 1'b0) ? resp_in : '0;
        resp_out[1] = (ack_fire && fifo_head == 1'b1) ? resp_in : '0;
    end

    assign m0_ack_o      = ack_fire & (fifo_head == 1'b0);
    assign m0_data_rd_o  = resp_out[0].data_rd;
    assign m0_error_o    = resp_out[0].error;
    assign m0_resp_tag_o = resp_out[0].tag;
    assign m1_ack_o      = ack_fire & (fifo_head == 1'b1);
    assign m1_data_rd_o  = resp_out[1].data_rd;
    assign m1_error_o    = resp_out[1].error;
    assign m1_resp_tag_o = resp_out[1].tag;

    assign busy_o = |fifo_count;

    // A refused grant stays locked until taken; a withdrawn request releases the lock.
    always_comb begin
        rr_d        = rr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        if (accept_fire) begin
            rr_d   = ~grant;
            lock_d = 1'b0;
        end else if (grant_req) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end else begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= 1'b0;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
        end
    end

    dport_arb_idfifo #(
        .DEPTH   (OUTSTANDING),
        .DEPTH_W (OUTSTANDING_W)
    ) u_idfifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (accept_fire),
        .push_id_i (grant),
        .pop_i     (ack_fire),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_dport_arb.sv
// Directed bench for dport_arb: per-cycle queue model plus hand-computed checkpoints.
module tb_dport_arb;

    localparam int TAG_W = 11;
    localparam int OUTS  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      m0_addr, m0_data_wr, m1_addr, m1_data_wr;
    logic             m0_rd, m1_rd, m0_cache, m1_cache;
    logic [3:0]       m0_wr, m1_wr;
    logic [TAG_W-1:0] m0_tag, m1_tag;
    logic             m0_inv, m0_wb, m0_flush, m1_inv, m1_wb, m1_flush;
    logic             m0_accept, m0_ack, m0_error, m1_accept, m1_ack, m1_error;
    logic [31:0]      m0_data_rd, m1_data_rd;
    logic [TAG_W-1:0] m0_resp_tag, m1_resp_tag;
    logic [31:0]      mem_addr, mem_data_wr, mem_data_rd;
    logic             mem_rd, mem_cache, mem_inv, mem_wb, mem_flush;
    logic [3:0]       mem_wr;
    logic [TAG_W-1:0] mem_req_tag, mem_resp_tag;
    logic             mem_accept, mem_ack, mem_error, busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dport_arb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_addr_i(m0_addr), .m0_data_wr_i(m0_data_wr), .m0_rd_i(m0_rd), .m0_wr_i(m0_wr),
        .m0_cacheable_i(m0_cache), .m0_req_tag_i(m0_tag), .m0_invalidate_i(m0_inv),
        .m0_writeback_i(m0_wb), .m0_flush_i(m0_flush), .m0_accept_o(m0_accept),
        .m0_ack_o(m0_ack), .m0_data_rd_o(m0_data_rd), .m0_error_o(m0_error),
        .m0_resp_tag_o(m0_resp_tag),
        .m1_addr_i(m1_addr), .m1_data_wr_i(m1_data_wr), .m1_rd_i(m1_rd), .m1_wr_i(m1_wr),
        .m1_cacheable_i(m1_cache), .m1_req_tag_i(m1_tag), .m1_invalidate_i(m1_inv),
        .m1_writeback_i(m1_wb), .m1_flush_i(m1_flush), .m1_accept_o(m1_accept),
        .m1_ack_o(m1_ack), .m1_data_rd_o(m1_data_rd), .m1_error_o(m1_error),
        .m1_resp_tag_o(m1_resp_tag),
        .mem_addr_o(mem_addr), .mem_data_wr_o(mem_data_wr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_cacheable_o(mem_cache), .mem_req_tag_o(mem_req_tag), .mem_invalidate_o(mem_inv),
        .mem_writeback_o(mem_wb), .mem_flush_o(mem_flush),
        .mem_accept_i(mem_accept), .mem_ack_i(mem_ack), .mem_data_rd_i(mem_data_rd),
        .mem_error_i(mem_error), .mem_resp_tag_i(mem_resp_tag), .busy_o(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: issue-order queue of master ids ----------------
    logic [0:0] exp_q[$];
    int mdl_prefer = 0;
    int mdl_held   = -1;

    always @(negedge clk) begin
        int r0, r1, g, gr, issue, acc, ackv, to;
        logic [31:0] e_addr;
        logic [3:0]  e_wr;
        logic        e_rd;
        if (!rst_n) begin
            exp_q.delete();
            mdl_prefer = 0;
            mdl_held   = -1;
            check("rst_accept", {m1_accept, m0_accept}, 32'd0);
            check("rst_ack", {m1_ack, m0_ack}, 32'd0);
            check("rst_busy", busy, 32'd0);
            check("rst_mem_rd", mem_rd, 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
        end else begin
            r0 = int'(m0_rd | (|m0_wr) | m0_inv | m0_wb | m0_flush);
            r1 = int'(m1_rd | (|m1_wr) | m1_inv | m1_wb | m1_flush);
            if (mdl_held >= 0)       g = mdl_held;
            else if (r0 != 0 && r1 == 0) g = 0;
            else if (r1 != 0 && r0 == 0) g = 1;
            else                     g = mdl_prefer;
            gr    = (g == 0) ? r0 : r1;
            issue = (gr != 0 && exp_q.size() < OUTS) ? 1 : 0;
            acc   = (issue != 0 && mem_accept) ? 1 : 0;
            e_addr = (issue == 0) ? 32'd0 : (g == 0 ? m0_addr : m1_addr);
            e_wr   = (issue == 0) ? 4'd0  : (g == 0 ? m0_wr : m1_wr);
            e_rd   = (issue == 0) ? 1'b0  : (g == 0 ? m0_rd : m1_rd);
            ackv = (mem_ack && exp_q.size() > 0) ? 1 : 0;
            to   = (ackv != 0) ? int'(exp_q[0]) : -1;

            check("mdl_m0_accept", m0_accept, (acc != 0 && g == 0) ? 32'd1 : 32'd0);
            check("mdl_m1_accept", m1_accept, (acc != 0 && g == 1) ? 32'd1 : 32'd0);
            check("mdl_mem_addr", mem_addr, e_addr);
            check("mdl_mem_wr", mem_wr, e_wr);
            check("mdl_mem_rd", mem_rd, e_rd);
            check("mdl_busy", busy, (exp_q.size() != 0) ? 32'd1 : 32'd0);
            check("mdl_m0_ack", m0_ack, (to == 0) ? 32'd1 : 32'd0);
            check("mdl_m1_ack", m1_ack, (to == 1) ? 32'd1 : 32'd0);
            if (to == 0) check("mdl_m0_data", m0_data_rd, mem_data_rd);
            if (to == 1) check("mdl_m1_data", m1_data_rd, mem_data_rd);
            if (to == 0) check("mdl_m0_tag", m0_resp_tag, mem_resp_tag);
            if (to == 1) check("mdl_m1_tag", m1_resp_tag, mem_resp_tag);

            if (ackv != 0) void'(exp_q.pop_front());
            if (acc != 0) begin
                exp_q.push_back(1'(g));
                mdl_prefer = 1 - g;
                mdl_held   = -1;
            end else if (gr != 0) begin
                mdl_held = g;
            end else begin
                mdl_held = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                            input logic [TAG_W-1:0] tag);
        m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_data_wr = addr ^ 32'h5A5A_0000; m0_tag = tag;
    endtask

    task automatic drive_m1(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                            input logic [TAG_W-1:0] tag);
        m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_data_wr = addr ^ 32'hA5A5_0000; m1_tag = tag;
    endtask

    task automatic idle();
        drive_m0(1'b0, 4'h0, 32'h0, '0);
        drive_m1(1'b0, 4'h0, 32'h0, '0);
        m0_cache = 1'b0; m0_inv = 1'b0; m0_wb = 1'b0; m0_flush = 1'b0;
        m1_cache = 1'b0; m1_inv = 1'b0; m1_wb = 1'b0; m1_flush = 1'b0;
        mem_accept = 1'b0; mem_ack = 1'b0; mem_data_rd = 32'h0; mem_error = 1'b0;
        mem_resp_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic ack_with(input logic [31:0] data, input logic [TAG_W-1:0] tag);
        mem_ack = 1'b1; mem_data_rd = data; mem_resp_tag = tag;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // Requests during reset must not leak out.
        drive_m0(1'b1, 4'h0, 32'h0000_0040, 11'd1);
        mem_accept = 1'b1;
        sample();
        check("reset_m0_accept", m0_accept, 32'd0);
        check("reset_mem_rd", mem_rd, 32'd0);
        check("reset_busy", busy, 32'd0);
        idle();
        step();
        rst_n = 1'b1;

        // 1: single m0 read, ack two cycles after accept
        drive_m0(1'b1, 4'h0, 32'h0000_0100, 11'd5);
        mem_accept = 1'b1;
        sample();
        check("t1_m0_accept", m0_accept, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h0000_0100);
        check("t1_mem_tag", 32'(mem_req_tag), 32'd5);
        step();
        idle();
        step();
        ack_with(32'hDEAD_BEEF, 11'd5);
        sample();
        check("t1_m0_ack", m0_ack, 32'd1);
        check("t1_m0_data", m0_data_rd, 32'hDEAD_BEEF);
        check("t1_m0_tag", 32'(m0_resp_tag), 32'd5);
        check("t1_m1_ack", m1_ack, 32'd0);
        check("t1_m1_data", m1_data_rd, 32'd0);
        step();
        idle();

        // 2: both request continuously, always accepted -> 0,1,0,1
        do_reset();
        drive_m0(1'b1, 4'h0, 32'h0000_1000, 11'h10);
        drive_m1(1'b1, 4'h0, 32'h0000_2000, 11'h20);
        mem_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t2_grant_m0", m0_accept, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_grant_m1", m1_accept, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            ack_with(32'h0000_00A0 + 32'(k), 11'(k));
            sample();
            check("t2_ack_m0", m0_ack, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_ack_m1", m1_ack, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("t2_ack_data", (k % 2 == 0) ? m0_data_rd : m1_data_rd, 32'h0000_00A0 + 32'(k));
            step();
        end
        idle();

        // 3: m1 write held across three refused cycles while m0 waits
        drive_m1(1'b0, 4'hF, 32'h0000_0200, 11'h33);
        sample();
        check("t3_mem_wr", mem_wr, 32'hF);
        check("t3_m1_accept_stall", m1_accept, 32'd0);
        step();
        drive_m0(1'b1, 4'h0, 32'h0000_0300, 11'h44);
        for (int k = 0; k < 2; k++) begin
            sample();
            check("t3_held_addr", mem_addr, 32'h0000_0200);
            step();
        end
        mem_accept = 1'b1;
        sample();
        check("t3_m1_accept", m1_accept, 32'd1);
        check("t3_m0_wait", m0_accept, 32'd0);
        step();
        drive_m1(1'b0, 4'h0, 32'h0, '0);
        sample();
        check("t3_m0_accept", m0_accept, 32'd1);
        check("t3_m0_addr", mem_addr, 32'h0000_0300);
        step();
        idle();
        ack_with(32'h1111_1111, 11'h33);
        sample();
        check("t3_ack_m1_first", m1_ack, 32'd1);
        step();
        ack_with(32'h2222_2222, 11'h44);
        sample();
        check("t3_ack_m0_second", m0_ack, 32'd1);
        step();
        idle();

        // 4: fill all four slots, stall, one ack, then accept again
        mem_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_m0(1'b1, 4'h0, 32'h0000_0400 + 32'(k * 4), 11'(k));
            sample();
            check("t4_fill_accept", m0_accept, 32'd1);
            step();
        end
        drive_m0(1'b1, 4'h0, 32'h0000_0410, 11'd4);
        sample();
        check("t4_full_accept", m0_accept, 32'd0);
        check("t4_full_mem_rd", mem_rd, 32'd0);
        check("t4_full_busy", busy, 32'd1);
        step();
        ack_with(32'h0000_0055, 11'd0);
        sample();
        check("t4_ack_cycle_accept", m0_accept, 32'd0);
        check("t4_ack_cycle_ack", m0_ack, 32'd1);
        step();
        mem_ack = 1'b0;
        sample();
        check("t4_reaccept", m0_accept, 32'd1);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            ack_with(32'h0000_0060 + 32'(k), 11'(k + 1));
            step();
        end
        idle();
        sample();
        check("t4_drained_busy", busy, 32'd0);
        step();

        // 5: accept+ack every cycle across FIFO wrap
        drive_m0(1'b1, 4'h0, 32'h0000_0500, 11'd7);
        mem_accept = 1'b1;
        step();
        drive_m1(1'b1, 4'h0, 32'h0000_0600, 11'd8);
        for (int k = 0; k < 10; k++) begin
            ack_with(32'h0000_0700 + 32'(k), 11'(k));
            sample();
            check("t5_busy", busy, 32'd1);
            check("t5_accept_m1", m1_accept, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t5_ack_m0", m0_ack, (k == 0 || (k - 1) % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        ack_with(32'h0000_07FF, 11'd9);
        sample();
        check("t5_last_ack_m0", m0_ack, 32'd1);
        step();
        idle();

        // 6: reset with two outstanding, then a stray ack
        drive_m0(1'b1, 4'h0, 32'h0000_0800, 11'd2);
        mem_accept = 1'b1;
        step();
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ack_with(32'h0BAD_0BAD, 11'd3);
        sample();
        check("t6_stray_ack_m0", m0_ack, 32'd0);
        check("t6_stray_ack_m1", m1_ack, 32'd0);
        check("t6_busy", busy, 32'd0);
        step();
        idle();
        drive_m0(1'b1, 4'h0, 32'h0000_0900, 11'd1);
        drive_m1(1'b1, 4'h0, 32'h0000_0A00, 11'd2);
        mem_accept = 1'b1;
        sample();
        check("t6_m0_first", m0_accept, 32'd1);
        check("t6_m1_waits", m1_accept, 32'd0);
        step();
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
